icache_direct: RTL

- Direct-mapped, read-only instruction cache sitting directly upstream of the instruction fetch queue.
- Takes the fetch PC and returns one full 128-bit line (4 instructions) plus a valid flag. The queue writes that line when its read enable is high.
- On a miss, a small FSM fills the line from main memory over a 32-bit request/beat interface.
- Hits return in the same cycle, so the queue's empty-bypass path sees zero added latency.

---
 rtl/icache_pkg.sv | 26 ++
 rtl/icache_tag_data_array.sv | 50 +++++
 rtl/icache_direct.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    WRITE
  } icache_state_t;

  localparam int OFFSET_BITS    = 4;
  localparam int WORDS_PER_LINE = 4;

  // Index width for a power-of-two line count.
  function automatic int idx_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Tag width left over once the line offset and index are removed.
  function automatic int tag_bits(input int data_width, input int num_lines);
    return data_width - OFFSET_BITS - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_tag_data_array.sv
// Valid/tag/data storage for the direct-mapped cache: one async read port, one sync write port.
// Latency: read is combinational; a write is visible to the read port the cycle after it is issued.
// Backpressure: none; a write is accepted every cycle wr_en is high.
module icache_tag_data_array
  import icache_pkg::*;
#(
  parameter int IDX_BITS   = 6,
  parameter int TAG_BITS   = 22,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_BITS-1:0]   rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [LINE_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_BITS-1:0]   wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [LINE_WIDTH-1:0] wr_data
);

  localparam int NUM_LINES = 1 << IDX_BITS;

  logic [NUM_LINES-1:0]  valid;
  logic [TAG_BITS-1:0]   tag_ram  [NUM_LINES];
  logic [LINE_WIDTH-1:0] data_ram [NUM_LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_ram[rd_idx];
  assign rd_data  = data_ram[rd_idx];

  // Valid bits: cleared by reset, set when a line is installed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_ram[wr_idx]  <= wr_tag;
      data_ram[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache returning a full 128-bit line per fetch PC.
// Latency: hits return in the same cycle; a miss fills over the beat bus and hits the cycle after WRITE.
// Backpressure: fetch_en gates lookups; mem_req holds until mem_ack, beats are accepted on mem_rvalid.
module icache_direct
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int NUM_LINES        = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       pc_in,
  input  logic                        fetch_en,
  input  logic                        flush,
  output logic [CACHE_LINE_WIDTH-1:0] d_out,
  output logic                        d_out_valid,
  output logic                        mem_req,
  output logic [DATA_WIDTH-1:0]       mem_addr,
  input  logic                        mem_ack,
  input  logic                        mem_rvalid,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  output logic                        miss_busy
);

  // NUM_LINES must be a power of two and at least 2 so the index field is non-empty.
  localparam int IDX_BITS = idx_bits(NUM_LINES);
  localparam int TAG_BITS = tag_bits(DATA_WIDTH, NUM_LINES);
  localparam int TAG_LSB  = OFFSET_BITS + IDX_BITS;

  icache_state_t state, state_nxt;

  logic [DATA_WIDTH-1:0]                      miss_addr;
  logic [1:0]                                 beat_cnt;
  logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0]  line_buf;

  logic [IDX_BITS-1:0]         lookup_idx;
  logic [TAG_BITS-1:0]         lookup_tag;
  logic [OFFSET_BITS-1:0]      unused_offset;
  logic                        rd_valid;
  logic [TAG_BITS-1:0]         rd_tag;
  logic [CACHE_LINE_WIDTH-1:0] rd_data;
  logic                        hit;
  logic                        miss_start;
  logic                        last_beat;

  assign lookup_idx    = pc_in[OFFSET_BITS +: IDX_BITS];
  assign lookup_tag    = pc_in[DATA_WIDTH-1:TAG_LSB];
  // The line offset never affects the lookup; the whole line is returned.
  assign unused_offset = pc_in[OFFSET_BITS-1:0];

  assign hit        = rd_valid && (rd_tag == lookup_tag);
  assign miss_start = (state == IDLE) && fetch_en && !hit && !flush;
  assign last_beat  = (state == FILL) && mem_rvalid && (beat_cnt == 2'd3);
  assign mem_addr   = miss_addr;

  icache_tag_data_array #(
    .IDX_BITS   (IDX_BITS),
    .TAG_BITS   (TAG_BITS),
    .LINE_WIDTH (CACHE_LINE_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (lookup_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (state == WRITE),
    .wr_idx   (miss_addr[OFFSET_BITS +: IDX_BITS]),
    .wr_tag   (miss_addr[DATA_WIDTH-1:TAG_LSB]),
    .wr_data  (line_buf)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and outputs; a flush outside IDLE is ignored so an in-flight fill always completes.
  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    miss_busy   = 1'b1;
    d_out       = '0;
    d_out_valid = 1'b0;
    case (state)
      IDLE: begin
        miss_busy   = 1'b0;
        d_out       = rd_data;
        d_out_valid = hit && fetch_en && !flush;
        if (miss_start) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (last_beat) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Miss address capture, beat counting and line assembly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      miss_addr <= '0;
      beat_cnt  <= '0;
      line_buf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_start) begin
            miss_addr <= {pc_in[DATA_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          end
        end
        REQ: begin
          if (mem_ack) begin
            beat_cnt <= '0;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            line_buf[beat_cnt] <= mem_rdata;
            beat_cnt           <= beat_cnt + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
